// File: rtl/pueo_thresh_pkg.sv
// rtl/pueo_thresh_pkg.sv - shared types and constants for the threshold loader
package pueo_thresh_pkg;

  localparam int TBITS = 18;

  localparam bit THR_SET_PRI = 1'b0;
  localparam bit THR_SET_SEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    SHIFT,
    COMMIT
  } thr_state_t;

  typedef struct packed {
    logic [TBITS-1:0] beam_b;
    logic [TBITS-1:0] beam_a;
  } thresh_pair_t;

  // Module-index width; a single-module cascade still needs one address bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pueo_threshold_loader_if.sv
// rtl/pueo_threshold_loader_if.sv - control and cascade signals of the threshold loader
interface pueo_threshold_loader_if #(
  parameter int NBEAMS = 24,
  parameter int TBITS  = 18
);
  import pueo_thresh_pkg::*;

  localparam int AW = idx_bits(NBEAMS);

  logic                 wr_en_i;
  logic                 wr_set_i;
  logic [AW-1:0]        wr_addr_i;
  logic [2*TBITS-1:0]   wr_data_i;
  logic                 start_i;
  logic                 start_set_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 wr_err_o;
  logic [2*TBITS-1:0]   thresh_o;
  logic [1:0]           thresh_wr_o;
  logic [1:0]           thresh_update_o;

  modport master (
    output wr_en_i, wr_set_i, wr_addr_i, wr_data_i, start_i, start_set_i,
    input  busy_o, done_o, wr_err_o, thresh_o, thresh_wr_o, thresh_update_o
  );

  modport slave (
    input  wr_en_i, wr_set_i, wr_addr_i, wr_data_i, start_i, start_set_i,
    output busy_o, done_o, wr_err_o, thresh_o, thresh_wr_o, thresh_update_o
  );

endinterface

// File: rtl/pueo_thresh_stage_ram.sv
// rtl/pueo_thresh_stage_ram.sv - simple dual-port staging RAM with registered read
module pueo_thresh_stage_ram #(
  parameter int AW = 6,
  parameter int DW = 36
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Read port with one cycle of latency.
  always_ff @(posedge clk_i) begin
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/pueo_threshold_loader.sv
// rtl/pueo_threshold_loader.sv - shifts a staged threshold set through the beam cascade and commits it
module pueo_threshold_loader #(
  parameter int NBEAMS = 24,
  parameter int TBITS  = pueo_thresh_pkg::TBITS
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pueo_threshold_loader_if.slave ctl
);
  import pueo_thresh_pkg::*;

  localparam int            AW       = idx_bits(NBEAMS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NBEAMS - 1);

  thr_state_t         state_q, state_n;
  logic               set_q;
  logic [AW-1:0]      idx_q;
  logic [AW-1:0]      rd_idx;
  logic [1:0]         rst_pipe_q;
  logic               run_ok;
  logic               wr_drop;
  logic               wr_err_q;
  logic [2*TBITS-1:0] rd_data;

  // Hold the FSM in IDLE for two clocks after reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rst_pipe_q <= 2'b11;
    else       rst_pipe_q <= {rst_pipe_q[0], 1'b0};
  end

  assign run_ok = ~rst_pipe_q[1];

  // State register, latched set and the index of the word presented in SHIFT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      set_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == IDLE && state_n == PRIME) begin
        set_q <= ctl.start_set_i;
        idx_q <= LAST_IDX;
      end else if (state_q == SHIFT && idx_q != '0) begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end

  // Next state, read address (one word ahead of idx_q) and state-decoded outputs.
  always_comb begin
    state_n             = state_q;
    rd_idx              = idx_q;
    ctl.busy_o          = 1'b0;
    ctl.done_o          = 1'b0;
    ctl.thresh_o        = '0;
    ctl.thresh_wr_o     = 2'b00;
    ctl.thresh_update_o = 2'b00;
    case (state_q)
      IDLE: begin
        rd_idx = LAST_IDX;
        if (ctl.start_i && run_ok) state_n = PRIME;
      end
      PRIME: begin
        ctl.busy_o = 1'b1;
        state_n    = SHIFT;
      end
      SHIFT: begin
        ctl.busy_o                   = 1'b1;
        ctl.thresh_o                 = rd_data;
        ctl.thresh_wr_o[THR_SET_PRI] = (set_q == THR_SET_PRI);
        ctl.thresh_wr_o[THR_SET_SEC] = (set_q == THR_SET_SEC);
        if (idx_q != '0) rd_idx  = idx_q - 1'b1;
        else             state_n = COMMIT;
      end
      COMMIT: begin
        ctl.busy_o                       = 1'b1;
        ctl.done_o                       = 1'b1;
        ctl.thresh_update_o[THR_SET_PRI] = (set_q == THR_SET_PRI);
        ctl.thresh_update_o[THR_SET_SEC] = (set_q == THR_SET_SEC);
        state_n                          = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Writes into the set being shifted would race the read port, so they are refused.
  assign wr_drop = ctl.wr_en_i && (state_q != IDLE) && (ctl.wr_set_i == set_q);

  // Flag a refused write one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wr_err_q <= 1'b0;
    else       wr_err_q <= wr_drop;
  end

  assign ctl.wr_err_o = wr_err_q;

  pueo_thresh_stage_ram #(
    .AW (AW + 1),
    .DW (2 * TBITS)
  ) u_stage_ram (
    .clk_i     (clk_i),
    .wr_en_i   (ctl.wr_en_i && !wr_drop),
    .wr_addr_i ({ctl.wr_set_i, ctl.wr_addr_i}),
    .wr_data_i (ctl.wr_data_i),
    .rd_addr_i ({set_q, rd_idx}),
    .rd_data_o (rd_data)
  );

endmodule

// File: tb/tb_pueo_threshold_loader.sv
// tb/tb_pueo_threshold_loader.sv - directed self-checking bench for the threshold loader
module tb_pueo_threshold_loader;
  import pueo_thresh_pkg::*;

  localparam int NB = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  pueo_threshold_loader_if #(.NBEAMS(NB), .TBITS(TBITS)) bus ();

  pueo_threshold_loader #(.NBEAMS(NB), .TBITS(TBITS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ctl   (bus)
  );

  // Cascade model: four dual-beam modules per set, shift on thresh_wr, commit on update.
  thresh_pair_t stage_q [0:1][0:NB-1];
  thresh_pair_t live_q  [0:1][0:NB-1];

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (bus.thresh_wr_o[s]) begin
        for (int m = NB - 1; m > 0; m--) stage_q[s][m] <= stage_q[s][m-1];
        stage_q[s][0] <= bus.thresh_o;
      end
      if (bus.thresh_update_o[s]) begin
        for (int m = 0; m < NB; m++) live_q[s][m] <= stage_q[s][m];
      end
    end
  end

  function automatic logic [2*TBITS-1:0] pack2(input int b, input int a);
    return {TBITS'(b), TBITS'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_write(input bit s, input int a, input logic [2*TBITS-1:0] d);
    bus.wr_en_i   = 1'b1;
    bus.wr_set_i  = s;
    bus.wr_addr_i = AW'(a);
    bus.wr_data_i = d;
    tick();
    bus.wr_en_i   = 1'b0;
  endtask

  task automatic do_load(input bit s);
    bus.start_i     = 1'b1;
    bus.start_set_i = s;
    tick();
    bus.start_i     = 1'b0;
    repeat (NB + 2) tick();
  endtask

  task automatic test_reset();
    total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy_o); else passed++;
    total++; if (bus.done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done_o); else passed++;
    total++; if (bus.wr_err_o !== 1'b0) $display("FAIL reset_wr_err: got %b expected 0", bus.wr_err_o); else passed++;
    total++; if (bus.thresh_o !== '0) $display("FAIL reset_thresh: got %h expected 0", bus.thresh_o); else passed++;
    total++; if (bus.thresh_wr_o !== 2'b00) $display("FAIL reset_thresh_wr: got %b expected 00", bus.thresh_wr_o); else passed++;
    total++; if (bus.thresh_update_o !== 2'b00) $display("FAIL reset_update: got %b expected 00", bus.thresh_update_o); else passed++;
  endtask

  task automatic test_basic_load();
    int n_wr;
    for (int k = 0; k < NB; k++) begin
      ram_write(1'b0, k, pack2(k + 'h100, k));
      ram_write(1'b1, k, pack2(k + 'h200, k + 'h10));
    end
    bus.start_i     = 1'b1;
    bus.start_set_i = 1'b0;
    tick();
    bus.start_i = 1'b0;
    n_wr = 0;
    for (int c = 1; c <= 7; c++) begin
      if (bus.thresh_wr_o !== 2'b00) n_wr++;
      if (c == 1) begin
        total++; if (bus.busy_o !== 1'b1) $display("FAIL basic_prime_busy: got %b expected 1", bus.busy_o); else passed++;
      end
      if (c >= 2 && c <= 5) begin
        total++; if (bus.thresh_wr_o !== 2'b01) $display("FAIL basic_thresh_wr c=%0d: got %b expected 01", c, bus.thresh_wr_o); else passed++;
        total++; if (bus.thresh_o !== pack2(5 - c + 'h100, 5 - c)) $display("FAIL basic_thresh c=%0d: got %h expected %h", c, bus.thresh_o, pack2(5 - c + 'h100, 5 - c)); else passed++;
      end
      if (c == 6) begin
        total++; if (bus.thresh_update_o !== 2'b01) $display("FAIL basic_update: got %b expected 01", bus.thresh_update_o); else passed++;
        total++; if (bus.done_o !== 1'b1) $display("FAIL basic_done: got %b expected 1", bus.done_o); else passed++;
        total++; if (bus.thresh_o !== '0) $display("FAIL basic_thresh_quiet: got %h expected 0", bus.thresh_o); else passed++;
      end
      if (c == 7) begin
        total++; if (bus.busy_o !== 1'b0) $display("FAIL basic_idle_busy: got %b expected 0", bus.busy_o); else passed++;
      end
      if (c < 7) tick();
    end
    total++; if (n_wr !== 4) $display("FAIL basic_wr_cycles: got %0d expected 4", n_wr); else passed++;
  endtask

  task automatic test_chain();
    for (int m = 0; m < NB; m++) begin
      total++; if (live_q[0][m] !== pack2(m + 'h100, m)) $display("FAIL chain_set0 m=%0d: got %h expected %h", m, live_q[0][m], pack2(m + 'h100, m)); else passed++;
    end
  endtask

  task automatic test_ignored_start();
    int n_done;
    int n_wr1;
    bus.start_i     = 1'b1;
    bus.start_set_i = 1'b0;
    tick();
    n_done = 0;
    n_wr1  = 0;
    for (int c = 1; c <= 16; c++) begin
      if (bus.done_o === 1'b1) n_done++;
      if (bus.thresh_wr_o[1] === 1'b1) n_wr1++;
      if (c == 3) begin
        bus.start_i     = 1'b1;
        bus.start_set_i = 1'b1;
      end else begin
        bus.start_i = 1'b0;
      end
      tick();
    end
    total++; if (n_done !== 1) $display("FAIL ignore_done_count: got %0d expected 1", n_done); else passed++;
    total++; if (n_wr1 !== 0) $display("FAIL ignore_wr1_count: got %0d expected 0", n_wr1); else passed++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL ignore_busy_end: got %b expected 0", bus.busy_o); else passed++;
  endtask

  task automatic test_busy_write();
    bus.start_i     = 1'b1;
    bus.start_set_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 2 || c == 4) begin
        total++; if (bus.wr_err_o !== 1'b0) $display("FAIL busy_wr_err_low c=%0d: got %b expected 0", c, bus.wr_err_o); else passed++;
      end
      if (c == 3) begin
        total++; if (bus.wr_err_o !== 1'b1) $display("FAIL busy_wr_err_pulse: got %b expected 1", bus.wr_err_o); else passed++;
      end
      bus.wr_en_i = (c == 2 || c == 3);
      bus.wr_set_i  = (c == 2);
      bus.wr_addr_i = AW'(2);
      bus.wr_data_i = (c == 2) ? pack2('h3ff, 'h3ff) : pack2('h155, 'h055);
      tick();
    end
    bus.wr_en_i = 1'b0;
    total++; if (live_q[1][2] !== pack2('h202, 'h12)) $display("FAIL busy_set1_load: got %h expected %h", live_q[1][2], pack2('h202, 'h12)); else passed++;
    do_load(1'b1);
    total++; if (live_q[1][2] !== pack2('h202, 'h12)) $display("FAIL busy_set1_unchanged: got %h expected %h", live_q[1][2], pack2('h202, 'h12)); else passed++;
    do_load(1'b0);
    total++; if (live_q[0][2] !== pack2('h155, 'h055)) $display("FAIL busy_set0_written: got %h expected %h", live_q[0][2], pack2('h155, 'h055)); else passed++;
    total++; if (live_q[0][3] !== pack2('h103, 3)) $display("FAIL busy_set0_other: got %h expected %h", live_q[0][3], pack2('h103, 3)); else passed++;
  endtask

  task automatic test_reset_midload();
    int n_up;
    int n_done;
    bus.start_i     = 1'b1;
    bus.start_set_i = 1'b0;
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    total++; if (bus.thresh_wr_o !== 2'b01) $display("FAIL mid_pre_shift: got %b expected 01", bus.thresh_wr_o); else passed++;
    rst = 1'b1;
    #1;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL mid_busy: got %b expected 0", bus.busy_o); else passed++;
    total++; if (bus.thresh_wr_o !== 2'b00) $display("FAIL mid_thresh_wr: got %b expected 00", bus.thresh_wr_o); else passed++;
    total++; if (bus.thresh_o !== '0) $display("FAIL mid_thresh: got %h expected 0", bus.thresh_o); else passed++;
    total++; if (bus.done_o !== 1'b0) $display("FAIL mid_done: got %b expected 0", bus.done_o); else passed++;
    n_up = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) rst = 1'b0;
      tick();
      if (bus.thresh_update_o !== 2'b00) n_up++;
    end
    total++; if (n_up !== 0) $display("FAIL mid_no_update: got %0d expected 0", n_up); else passed++;
    total++; if (live_q[0][0] !== pack2('h100, 0)) $display("FAIL mid_chain_kept: got %h expected %h", live_q[0][0], pack2('h100, 0)); else passed++;
    bus.start_i     = 1'b1;
    bus.start_set_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.done_o === 1'b1 && bus.thresh_update_o === 2'b10) n_done++;
      tick();
    end
    total++; if (n_done !== 1) $display("FAIL mid_reload_done: got %0d expected 1", n_done); else passed++;
    total++; if (live_q[1][3] !== pack2('h203, 'h13)) $display("FAIL mid_reload_chain: got %h expected %h", live_q[1][3], pack2('h203, 'h13)); else passed++;
  endtask

  task automatic test_back_to_back();
    int up_c1;
    int up_c2;
    int n_done;
    bit issued;
    bus.start_i     = 1'b1;
    bus.start_set_i = 1'b0;
    tick();
    bus.start_i = 1'b0;
    up_c1  = -1;
    up_c2  = -1;
    n_done = 0;
    issued = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (bus.thresh_update_o[0] === 1'b1) begin
        if (up_c1 < 0) up_c1 = c;
        else           up_c2 = c;
      end
      if (bus.done_o === 1'b1) n_done++;
      if (!issued && c > 1 && bus.busy_o === 1'b0) begin
        bus.start_i = 1'b1;
        issued      = 1'b1;
      end else begin
        bus.start_i = 1'b0;
      end
      tick();
    end
    total++; if (up_c1 !== 6) $display("FAIL b2b_first_update: got %0d expected 6", up_c1); else passed++;
    total++; if (up_c2 !== 6 + NB + 3) $display("FAIL b2b_second_update: got %0d expected %0d", up_c2, 6 + NB + 3); else passed++;
    total++; if (n_done !== 2) $display("FAIL b2b_done_count: got %0d expected 2", n_done); else passed++;
  endtask

  initial begin
    bus.wr_en_i     = 1'b0;
    bus.wr_set_i    = 1'b0;
    bus.wr_addr_i   = '0;
    bus.wr_data_i   = '0;
    bus.start_i     = 1'b0;
    bus.start_set_i = 1'b0;
    repeat (3) tick();
    test_reset();
    rst = 1'b0;
    repeat (3) tick();
    test_basic_load();
    test_chain();
    test_ignored_start();
    test_busy_write();
    test_reset_midload();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
